ml_scheduler: RTL and testbench
===============================

Name: ml_scheduler

Overview:
- Sequences the ML demodulator datapath. Accepts symbol jobs (y_hat, R) from upstream QR stage into a 2-entry ping-pong buffer.
- Launches one job at a time on the datapath and waits for its hard-bit completion.
- Gates launches on credits from the 16-byte hard-bit output controller, so that controller never overflows.
- Sits between the QR/preprocessing stage and the ML datapath + output controller.

Parameters:
Y_WIDTH, 160, width of y_hat job vector
R_WIDTH, 320, width of R job vector
FIFO_DEPTH, 16, byte capacity of downstream hard-bit output controller (initial credits)
WDOG_CYCLES, 72, max cycles from launch to i_ml_done before timeout (datapath nominal 64)

Ports:
i_clk  in  1  clock, all state on rising edge
i_reset_n  in  1  asynchronous active-low reset
i_trig  in  1  job valid pulse from upstream; accepted only when o_in_rdy=1
i_y_hat  in  Y_WIDTH  job y_hat, sampled with i_trig
i_r  in  R_WIDTH  job R, sampled with i_trig
o_in_rdy  out  1  buffer has a free entry
o_ml_start  out  1  one-cycle launch pulse to datapath
o_ml_y_hat  out  Y_WIDTH  operand to datapath, stable from start until done
o_ml_r  out  R_WIDTH  operand to datapath, stable from start until done
i_ml_done  in  1  datapath result valid (byte written to output controller)
i_byte_pop  in  1  output controller finished shifting out one byte
o_busy  out  1  state != IDLE or buffer non-empty
o_credit  out  5  free downstream byte slots (0..FIFO_DEPTH)
o_err  out  1  sticky: i_trig while !o_in_rdy, or spurious i_ml_done
o_timeout  out  1  sticky: watchdog expired

Behaviour:
- Reset (async assert, sync release):
  - o_ml_start=0, operands=0, o_credit=FIFO_DEPTH, o_in_rdy=1.
  - o_busy=0, o_err=0, o_timeout=0; buffer empty, wr/rd pointers 0, state IDLE.
- Buffer: 2 entries.
  - wr_ptr toggles on accept (i_trig && o_in_rdy); rd_ptr toggles on launch.
  - count 0..2; o_in_rdy = (count<2), combinational from registers.
  - Accept and launch in the same cycle: count unchanged.
- i_trig while count==2: job dropped, buffer untouched, o_err set.
- FSM:
  - IDLE: if count>0 and o_credit>0, go to LAUNCH.
  - LAUNCH (one cycle): o_ml_start=1; operands registered from buffer[rd_ptr]; rd_ptr toggles; credit -1; watchdog cleared; go to WAIT.
  - WAIT: on i_ml_done go to IDLE. If watchdog reaches WDOG_CYCLES, set o_timeout, return the credit (+1), go to IDLE.
- Latency: with empty buffer, IDLE and credit>0, i_trig at edge t gives o_ml_start high in cycle t+2 (t+1 IDLE->LAUNCH). Minimum launch-to-launch is 3 cycles plus datapath time.
- Credits:
  - +1 on i_byte_pop, -1 on launch; both in the same cycle leaves it unchanged.
  - i_byte_pop at credit==FIFO_DEPTH is ignored (saturate) and sets o_err.
  - Credit 0 holds FSM in IDLE; launch occurs the cycle after a pop restores credit.
- i_ml_done outside WAIT: ignored, o_err set.
- i_ml_done in the same cycle the watchdog expires: done wins, no timeout.
- Operands hold value after done until the next LAUNCH.
- Reset mid-job: everything returns to reset values immediately; datapath must also be reset by the same signal.

Decomposition:
- Shared package ml_pkg: state encoding (IDLE, LAUNCH, WAIT), FIFO_DEPTH, Y/R widths, credit width.
- One sub-module: ml_job_buf, the 2-entry ping-pong buffer with count/rdy. FSM, credit counter and watchdog stay in ml_scheduler.

Test Plan:
- Single job: reset, i_trig y_hat=160'h1 at edge 0, i_ml_done 64 cycles after start → o_ml_start pulse at cycle 2, o_credit 16→15, o_busy 0 after done.
- Back-to-back: three i_trig on consecutive edges, done held off → first two accepted, third sets o_err, o_in_rdy=0; jobs launch in order 1,2.
- Credit stall: 16 jobs completed, no pops → o_credit=0, 17th job waits in buffer; one i_byte_pop → o_ml_start two cycles later, credit stays 0.
- Simultaneous pop and launch at credit 5 → credit remains 5; accept+launch same cycle keeps count.
- Watchdog: no i_ml_done for 72 cycles → o_timeout=1, credit restored to 16, next buffered job launches.
- Async reset asserted mid-WAIT (not on clock edge) → all outputs at reset values immediately; post-release job runs normally.

Source files
------------

// File: rtl/ml_pkg.sv
// ml_pkg: shared state encoding and sizing for the ML demodulator scheduler
package ml_pkg;
    localparam int ML_Y_W         = 160;
    localparam int ML_R_W         = 320;
    localparam int ML_FIFO_DEPTH  = 16;
    localparam int ML_CRED_W      = 5;
    localparam int ML_WDOG_CYCLES = 72;
    typedef enum logic [1:0] {ST_IDLE, ST_LAUNCH, ST_WAIT} state_e;
endpackage

// File: rtl/ml_job_buf.sv
// ml_job_buf: two-entry ping-pong buffer of (y_hat, R) jobs with occupancy and ready
module ml_job_buf
    import ml_pkg::*;
#(
    parameter int YW = ML_Y_W,
    parameter int RW = ML_R_W
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [YW-1:0] y_i,
    input  logic [RW-1:0] r_i,
    output logic [YW-1:0] y_o,
    output logic [RW-1:0] r_o,
    output logic [1:0]    count_o,
    output logic          rdy_o
);
    logic [YW-1:0] y_q [2];
    logic [RW-1:0] r_q [2];
    logic          wr_q, wr_d, rd_q, rd_d, acc, take;
    logic [1:0]    cnt_q, cnt_d;

    assign rdy_o   = cnt_q < 2'd2;
    assign count_o = cnt_q;
    assign y_o     = y_q[rd_q];
    assign r_o     = r_q[rd_q];

    // A full buffer drops the push; an empty one ignores the pop
    always_comb begin
        acc   = push_i && rdy_o;
        take  = pop_i && cnt_q != 2'd0;
        wr_d  = wr_q ^ acc;
        rd_d  = rd_q ^ take;
        cnt_d = cnt_q + 2'(acc) - 2'(take);
    end

    // Storage, pointers and occupancy
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            y_q   <= '{default: '0};
            r_q   <= '{default: '0};
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            if (acc) begin
                y_q[wr_q] <= y_i;
                r_q[wr_q] <= r_i;
            end
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/ml_scheduler.sv
// ml_scheduler: buffers QR jobs and launches them on the ML datapath under output-credit control
module ml_scheduler
    import ml_pkg::*;
#(
    parameter int Y_WIDTH     = ML_Y_W,
    parameter int R_WIDTH     = ML_R_W,
    parameter int FIFO_DEPTH  = ML_FIFO_DEPTH,
    parameter int WDOG_CYCLES = ML_WDOG_CYCLES
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_trig,
    input  logic [Y_WIDTH-1:0]   i_y_hat,
    input  logic [R_WIDTH-1:0]   i_r,
    output logic                 o_in_rdy,
    output logic                 o_ml_start,
    output logic [Y_WIDTH-1:0]   o_ml_y_hat,
    output logic [R_WIDTH-1:0]   o_ml_r,
    input  logic                 i_ml_done,
    input  logic                 i_byte_pop,
    output logic                 o_busy,
    output logic [ML_CRED_W-1:0] o_credit,
    output logic                 o_err,
    output logic                 o_timeout
);
    localparam int CW = ML_CRED_W;
    localparam int WW = $clog2(WDOG_CYCLES + 1);

    state_e             state_q, state_d;
    logic [CW-1:0]      credit_q, credit_d;
    logic [CW:0]        csum;
    logic [WW-1:0]      wdog_q, wdog_d;
    logic [Y_WIDTH-1:0] op_y_q, op_y_d, buf_y;
    logic [R_WIDTH-1:0] op_r_q, op_r_d, buf_r;
    logic [1:0]         cnt;
    logic               rdy, go, launch, timeout, pop_ok, err_q, err_d, to_q, to_d;

    ml_job_buf #(.YW(Y_WIDTH), .RW(R_WIDTH)) u_buf (
        .clk_i   (i_clk),
        .rst_ni  (i_reset_n),
        .push_i  (i_trig),
        .pop_i   (launch),
        .y_i     (i_y_hat),
        .r_i     (i_r),
        .y_o     (buf_y),
        .r_o     (buf_r),
        .count_o (cnt),
        .rdy_o   (rdy)
    );

    assign o_in_rdy   = rdy;
    assign o_ml_y_hat = op_y_q;
    assign o_ml_r     = op_r_q;
    assign o_credit   = credit_q;
    assign o_err      = err_q;
    assign o_timeout  = to_q;

    // FSM state register
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) state_q <= ST_IDLE;
        else            state_q <= state_d;
    end

    // FSM next state: a late done still beats the watchdog
    always_comb begin
        case (state_q)
            ST_IDLE:   state_d = go ? ST_LAUNCH : ST_IDLE;
            ST_LAUNCH: state_d = ST_WAIT;
            ST_WAIT:   state_d = (i_ml_done || timeout) ? ST_IDLE : ST_WAIT;
            default:   state_d = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        o_ml_start = state_q == ST_LAUNCH;
        o_busy     = state_q != ST_IDLE || cnt != 2'd0;
    end

    // Operands are captured entering LAUNCH so they are valid with the start pulse; the entry and credit are consumed as LAUNCH ends
    always_comb begin
        go       = state_q == ST_IDLE && cnt != 2'd0 && credit_q != '0;
        launch   = state_q == ST_LAUNCH;
        timeout  = state_q == ST_WAIT && !i_ml_done && wdog_q >= WW'(WDOG_CYCLES);
        pop_ok   = i_byte_pop && credit_q != CW'(FIFO_DEPTH);
        csum     = {1'b0, credit_q} + (CW+1)'(pop_ok) + (CW+1)'(timeout) - (CW+1)'(launch);
        credit_d = (csum > (CW+1)'(FIFO_DEPTH)) ? CW'(FIFO_DEPTH) : csum[CW-1:0];
        wdog_d   = (state_q == ST_IDLE) ? '0 : wdog_q + WW'(1);
        op_y_d   = go ? buf_y : op_y_q;
        op_r_d   = go ? buf_r : op_r_q;
        err_d    = err_q | (i_trig && !rdy) | (i_byte_pop && !pop_ok) | (i_ml_done && state_q != ST_WAIT);
        to_d     = to_q | timeout;
    end

    // Credit, watchdog, operand and sticky flag registers
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            credit_q <= CW'(FIFO_DEPTH);
            wdog_q   <= '0;
            op_y_q   <= '0;
            op_r_q   <= '0;
            err_q    <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            credit_q <= credit_d;
            wdog_q   <= wdog_d;
            op_y_q   <= op_y_d;
            op_r_q   <= op_r_d;
            err_q    <= err_d;
            to_q     <= to_d;
        end
    end
endmodule

// File: tb/tb_ml_scheduler.sv
// tb_ml_scheduler: table-driven and scoreboarded checks of the ML job scheduler
module tb_ml_scheduler;
    typedef struct packed {
        logic [159:0] y;
        logic [319:0] r;
    } job_t;
    typedef struct {
        logic [159:0] y;
        logic [319:0] r;
        int           lat;
        bit           pop;
        int           exp_credit;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n, trig, done, pop;
    logic [159:0] y_in, ml_y;
    logic [319:0] r_in, ml_r;
    logic         in_rdy, start, busy, err, tmo;
    logic [4:0]   credit;
    int           n_err = 0;
    int           n_checks = 0;
    int           prev;
    job_t         sb[$];
    job_t         exp_job, ja, jb, jc;
    vec_t         tbl[5];

    ml_scheduler dut (
        .i_clk      (clk),
        .i_reset_n  (rst_n),
        .i_trig     (trig),
        .i_y_hat    (y_in),
        .i_r        (r_in),
        .o_in_rdy   (in_rdy),
        .o_ml_start (start),
        .o_ml_y_hat (ml_y),
        .o_ml_r     (ml_r),
        .i_ml_done  (done),
        .i_byte_pop (pop),
        .o_busy     (busy),
        .o_credit   (credit),
        .o_err      (err),
        .o_timeout  (tmo)
    );

    always #5 clk = ~clk;

    function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endfunction

    function automatic void check_w(string nm, logic [319:0] act, logic [319:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endfunction

    function automatic job_t rnd_job();
        job_t j;
        for (int k = 0; k < 5; k++) j.y[k*32 +: 32] = $urandom();
        for (int k = 0; k < 10; k++) j.r[k*32 +: 32] = $urandom();
        return j;
    endfunction

    // Scoreboard: every launch must present the oldest accepted job's operands
    always @(negedge clk) begin
        if (start) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL sb_order: got a launch, required no launch (no job queued)");
            end else begin
                exp_job = sb.pop_front();
                check_w("sb_y_hat", 320'(ml_y), 320'(exp_job.y));
                check_w("sb_r", ml_r, exp_job.r);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input job_t j);
        y_in = j.y;
        r_in = j.r;
        trig = 1'b1;
        sb.push_back(j);
        tick(1);
        trig = 1'b0;
    endtask

    task automatic wait_start();
        int n;
        n = 0;
        while (start !== 1'b1 && n < 100) begin
            tick(1);
            n++;
        end
        check("start_seen", 32'(start), 1);
    endtask

    task automatic pulse_done();
        done = 1'b1;
        tick(1);
        done = 1'b0;
    endtask

    task automatic run_job(input job_t j, input int lat);
        send(j);
        wait_start();
        tick(lat);
        pulse_done();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        trig  = 1'b0;
        done  = 1'b0;
        pop   = 1'b0;
        tick(2);
        rst_n = 1'b1;
        sb.delete();
        tick(1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, required finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        trig  = 1'b0;
        done  = 1'b0;
        pop   = 1'b0;
        y_in  = '0;
        r_in  = '0;
        tbl[0] = '{160'h1, 320'h3, 64, 1'b0, 15};
        tbl[1] = '{160'hdead_beef, 320'h1234_5678, 1, 1'b1, 15};
        tbl[2] = '{{5{32'ha5a5_5a5a}}, {10{32'h0f0f_f0f0}}, 10, 1'b0, 14};
        tbl[3] = '{160'h7, 320'h9, 72, 1'b1, 14};
        tbl[4] = '{160'hffff, 320'h0, 40, 1'b0, 13};
        tick(2);
        rst_n = 1'b1;
        tick(1);
        check("rst_start", 32'(start), 0);
        check_w("rst_y_hat", 320'(ml_y), '0);
        check_w("rst_r", ml_r, '0);
        check("rst_credit", 32'(credit), 16);
        check("rst_in_rdy", 32'(in_rdy), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_err", 32'(err), 0);
        check("rst_timeout", 32'(tmo), 0);
        // single jobs: launch latency, credit timing, done latency incl. the done-at-expiry boundary
        for (int i = 0; i < 5; i++) begin
            prev = (i == 0) ? 16 : tbl[i-1].exp_credit;
            y_in = tbl[i].y;
            r_in = tbl[i].r;
            trig = 1'b1;
            sb.push_back('{tbl[i].y, tbl[i].r});
            tick(1);
            trig = 1'b0;
            check("tbl_start_early", 32'(start), 0);
            check("tbl_busy_accepted", 32'(busy), 1);
            tick(1);
            check("tbl_start", 32'(start), 1);
            check("tbl_credit_launch", 32'(credit), prev);
            tick(1);
            check("tbl_start_one_cycle", 32'(start), 0);
            check("tbl_credit_wait", 32'(credit), prev - 1);
            tick(tbl[i].lat - 1);
            pulse_done();
            check("tbl_busy_done", 32'(busy), 0);
            check("tbl_timeout", 32'(tmo), 0);
            check_w("tbl_y_hold", 320'(ml_y), 320'(tbl[i].y));
            if (tbl[i].pop) begin
                pop = 1'b1;
                tick(1);
                pop = 1'b0;
            end
            check("tbl_credit_end", 32'(credit), tbl[i].exp_credit);
            tick(1);
        end
        // back-to-back triggers: third is dropped, first two launch in order
        check("b2b_err_before", 32'(err), 0);
        ja = rnd_job();
        jb = rnd_job();
        jc = rnd_job();
        y_in = ja.y;
        r_in = ja.r;
        trig = 1'b1;
        sb.push_back(ja);
        tick(1);
        y_in = jb.y;
        r_in = jb.r;
        sb.push_back(jb);
        tick(1);
        check("b2b_in_rdy_full", 32'(in_rdy), 0);
        check("b2b_start_a", 32'(start), 1);
        y_in = jc.y;
        r_in = jc.r;
        tick(1);
        trig = 1'b0;
        check("b2b_err", 32'(err), 1);
        check("b2b_in_rdy_after", 32'(in_rdy), 1);
        tick(4);
        pulse_done();
        wait_start();
        tick(3);
        pulse_done();
        tick(3);
        check("b2b_idle", 32'(busy), 0);
        check("b2b_credit", 32'(credit), 11);
        check("b2b_sb_drained", 32'(sb.size()), 0);
        do_reset();
        // spurious done and pop at full credit are ignored but flagged
        pulse_done();
        check("spur_done_err", 32'(err), 1);
        check("spur_done_busy", 32'(busy), 0);
        check("spur_done_credit", 32'(credit), 16);
        do_reset();
        pop = 1'b1;
        tick(1);
        pop = 1'b0;
        check("pop_full_credit", 32'(credit), 16);
        check("pop_full_err", 32'(err), 1);
        do_reset();
        // credit accounting down to a stall
        for (int i = 0; i < 11; i++) run_job(rnd_job(), 1);
        check("cs_credit_11", 32'(credit), 5);
        ja = rnd_job();
        send(ja);
        tick(1);
        check("cs_start_x", 32'(start), 1);
        check("cs_credit_at_x", 32'(credit), 5);
        jb = rnd_job();
        y_in = jb.y;
        r_in = jb.r;
        trig = 1'b1;
        sb.push_back(jb);
        pop = 1'b1;
        tick(1);
        trig = 1'b0;
        pop = 1'b0;
        check("cs_pop_and_launch", 32'(credit), 5);
        check("cs_accept_and_launch", 32'(in_rdy), 1);
        send(rnd_job());
        check("cs_full", 32'(in_rdy), 0);
        tick(2);
        pulse_done();
        wait_start();
        tick(2);
        pulse_done();
        wait_start();
        tick(2);
        pulse_done();
        check("cs_credit_3", 32'(credit), 3);
        for (int i = 0; i < 3; i++) run_job(rnd_job(), 1);
        check("cs_credit_0", 32'(credit), 0);
        send(rnd_job());
        tick(5);
        check("cs_stall_start", 32'(start), 0);
        check("cs_stall_busy", 32'(busy), 1);
        check("cs_stall_credit", 32'(credit), 0);
        pop = 1'b1;
        tick(1);
        pop = 1'b0;
        check("cs_pop_then_idle", 32'(start), 0);
        tick(1);
        check("cs_pop_then_launch", 32'(start), 1);
        tick(1);
        check("cs_credit_after_launch", 32'(credit), 0);
        tick(2);
        pulse_done();
        check("cs_done_busy", 32'(busy), 0);
        do_reset();
        // watchdog: expiry returns the credit and the buffered job launches next
        send(rnd_job());
        wait_start();
        send(rnd_job());
        tick(71);
        check("wd_not_yet", 32'(tmo), 0);
        check("wd_credit_held", 32'(credit), 15);
        tick(1);
        check("wd_timeout", 32'(tmo), 1);
        check("wd_credit_back", 32'(credit), 16);
        check("wd_idle", 32'(start), 0);
        tick(1);
        check("wd_next_launch", 32'(start), 1);
        tick(2);
        pulse_done();
        check("wd_sticky", 32'(tmo), 1);
        check("wd_credit_end", 32'(credit), 15);
        // asynchronous reset in the middle of WAIT
        send(rnd_job());
        wait_start();
        tick(5);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_start", 32'(start), 0);
        check_w("ar_y_hat", 320'(ml_y), '0);
        check_w("ar_r", ml_r, '0);
        check("ar_credit", 32'(credit), 16);
        check("ar_in_rdy", 32'(in_rdy), 1);
        check("ar_busy", 32'(busy), 0);
        check("ar_err", 32'(err), 0);
        check("ar_timeout", 32'(tmo), 0);
        sb.delete();
        tick(2);
        rst_n = 1'b1;
        tick(1);
        run_job(rnd_job(), 20);
        check("ar_post_credit", 32'(credit), 15);
        check("ar_post_busy", 32'(busy), 0);
        check("ar_post_timeout", 32'(tmo), 0);
        tick(2);
        check("sb_all_launched", 32'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
